// File: rtl/line_pkg.sv
// Shared constants and state encoding for the line feeder and its buffers.
package line_pkg;
    localparam int WIDTH = 25;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        FINISH = 2'd3
    } state_t;
endpackage

// File: rtl/line_feeder_if.sv
// Feeder-to-core line handshake: the feeder presents a line, the core returns one result word.
interface line_feeder_if;
    logic                       start;
    logic [line_pkg::WIDTH-1:0] line;
    logic [line_pkg::AW-1:0]    count;
    logic                       coreDone;
    logic [line_pkg::WIDTH-1:0] coreResult;

    modport master (output start, line, count, input coreDone, coreResult);
    modport slave  (input start, line, count, output coreDone, coreResult);
endinterface

// File: rtl/line_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read, contents never reset.
module line_ram #(
    parameter int W = 25,
    parameter int D = 64,
    parameter int A = 6
) (
    input  logic         clk,
    input  logic         we,
    input  logic [A-1:0] waddr,
    input  logic [W-1:0] wdata,
    input  logic [A-1:0] raddr,
    output logic [W-1:0] rdata
);
    logic [W-1:0] mem [D];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/line_feeder.sv
// Steps a host-loaded line buffer through the core one line at a time via start/done,
// collecting each core result into a host-readable result buffer.
module line_feeder
    import line_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wrEn,
    input  logic [AW-1:0]    wrAddr,
    input  logic [WIDTH-1:0] wrData,
    input  logic             go,
    input  logic [AW-1:0]    rdAddr,
    output logic [WIDTH-1:0] rdData,
    output logic             busy,
    output logic             finished,
    line_feeder_if.master    core
);
    state_t           state, state_n;
    logic [AW-1:0]    count_q;
    logic [WIDTH-1:0] line_q;
    logic             finished_q;
    logic [AW-1:0]    in_raddr;
    logic [WIDTH-1:0] in_rdata;
    logic             in_we, res_we, accept, advance, last;

    assign busy     = (state == ISSUE) || (state == WAIT);
    assign accept   = (state == IDLE) && go;
    assign advance  = (state == WAIT) && core.coreDone;
    assign last     = (count_q == AW'(DEPTH - 1));
    assign in_we    = wrEn && !busy;
    assign res_we   = advance;
    // Read port looks ahead: line 0 while idle, otherwise the line after the current one.
    assign in_raddr = (state == IDLE) ? '0 : count_q + AW'(1);

    line_ram #(.W(WIDTH), .D(DEPTH), .A(AW)) inbuf (
        .clk   (clk),
        .we    (in_we),
        .waddr (wrAddr),
        .wdata (wrData),
        .raddr (in_raddr),
        .rdata (in_rdata)
    );

    line_ram #(.W(WIDTH), .D(DEPTH), .A(AW)) resbuf (
        .clk   (clk),
        .we    (res_we),
        .waddr (count_q),
        .wdata (core.coreResult),
        .raddr (rdAddr),
        .rdata (rdData)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (go) state_n = ISSUE;
            ISSUE:   state_n = WAIT;
            WAIT:    if (core.coreDone) state_n = last ? FINISH : ISSUE;
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q    <= '0;
            line_q     <= '0;
            finished_q <= 1'b0;
        end else begin
            if (accept) begin
                count_q    <= '0;
                line_q     <= in_rdata;
                finished_q <= 1'b0;
            end else if (advance && !last) begin
                count_q <= count_q + AW'(1);
                line_q  <= in_rdata;
            end else if (state == FINISH) begin
                finished_q <= 1'b1;
            end
        end
    end

    assign core.start = (state == ISSUE);
    assign core.line  = line_q;
    assign core.count = count_q;
    assign finished   = finished_q;
endmodule

// File: tb/tb_line_feeder.sv
// Directed bench for line_feeder with a small core model answering each start.
module tb_line_feeder;
    import line_pkg::*;

    localparam logic [WIDTH-1:0] MASK = 25'h1FFFFFF;

    logic             clk = 1'b0;
    logic             rst;
    logic             wrEn;
    logic [AW-1:0]    wrAddr;
    logic [WIDTH-1:0] wrData;
    logic             go;
    logic [AW-1:0]    rdAddr;
    logic [WIDTH-1:0] rdData;
    logic             busy;
    logic             finished;

    line_feeder_if cif ();

    line_feeder dut (
        .clk      (clk),
        .rst      (rst),
        .wrEn     (wrEn),
        .wrAddr   (wrAddr),
        .wrData   (wrData),
        .go       (go),
        .rdAddr   (rdAddr),
        .rdData   (rdData),
        .busy     (busy),
        .finished (finished),
        .core     (cif.master)
    );

    always #5 clk = ~clk;

    int               vec  = 0;
    int               miss = 0;
    int               mode = 0;   // 0: core silent, 1: done 3 cycles after start, 2: done held high
    int               dly  = 0;
    int               mon_n = 0;
    int               mon_bad = 0;
    logic [WIDTH-1:0] tb_in [DEPTH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pulse_go();
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int t;
        t = 0;
        while (!finished && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk(tag, 32'(finished), 32'd1);
    endtask

    // Core model
    initial begin
        cif.coreDone   = 1'b0;
        cif.coreResult = '0;
        forever begin
            @(negedge clk);
            cif.coreDone = 1'b0;
            if (mode == 2) begin
                cif.coreDone   = 1'b1;
                cif.coreResult = cif.line ^ MASK;
            end else if (mode == 1) begin
                if (dly > 0) begin
                    dly--;
                    if (dly == 0) begin
                        cif.coreDone   = 1'b1;
                        cif.coreResult = cif.line ^ MASK;
                    end
                end
                if (cif.start) dly = 3;
            end
        end
    end

    // Start monitor: each start must present the next index and its expected line
    initial begin
        forever begin
            @(negedge clk);
            if (cif.start === 1'b1) begin
                if (cif.count !== mon_n[AW-1:0] || cif.line !== tb_in[mon_n[AW-1:0]]) mon_bad++;
                mon_n++;
            end
        end
    end

    initial begin
        rst = 1'b0; wrEn = 1'b0; wrAddr = '0; wrData = '0; go = 1'b0; rdAddr = '0;
        repeat (3) @(negedge clk);
        chk("rst_line", 32'(cif.line), 32'd0);
        chk("rst_count", 32'(cif.count), 32'd0);
        chk("rst_start", 32'(cif.start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_finished", 32'(finished), 32'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_count", 32'(cif.count), 32'd0);
        chk("idle_start", 32'(cif.start), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        // Load input buffer
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            wrEn = 1'b1; wrAddr = AW'(i); wrData = WIDTH'(i + 'h100);
            tb_in[i] = WIDTH'(i + 'h100);
        end
        @(negedge clk);
        wrEn = 1'b0;

        // Full run with delayed core
        mode = 1; mon_n = 0; mon_bad = 0;
        pulse_go();
        chk("go_to_start", 32'(cif.start), 32'd1);
        wait_done("run1_done");
        chk("run1_starts", 32'(mon_n), 32'd64);
        chk("run1_seq", 32'(mon_bad), 32'd0);
        chk("run1_count", 32'(cif.count), 32'd63);
        chk("run1_busy", 32'(busy), 32'd0);
        rdAddr = 6'd5; #1;
        chk("res5", 32'(rdData), 32'h1FFFEFA);
        rdAddr = 6'd63; #1;
        chk("res63", 32'(rdData), 32'h1FFFEC0);

        // Mid-run go and write are ignored
        mon_n = 0; mon_bad = 0;
        pulse_go();
        repeat (9) @(negedge clk);
        go = 1'b1; wrEn = 1'b1; wrAddr = '0; wrData = 25'h0AAAAAA;
        @(negedge clk);
        go = 1'b0; wrEn = 1'b0;
        wait_done("run2_done");
        chk("run2_starts", 32'(mon_n), 32'd64);
        chk("run2_seq", 32'(mon_bad), 32'd0);

        // Core done held high: one line per two cycles
        mode = 2; mon_n = 0; mon_bad = 0;
        pulse_go();
        chk("hh_start", 32'(cif.start), 32'd1);
        chk("hh_line0", 32'(cif.line), 32'h100);
        repeat (127) @(negedge clk);
        chk("hh_busy_last", 32'(busy), 32'd1);
        @(negedge clk);
        chk("hh_busy_off", 32'(busy), 32'd0);
        chk("hh_fin_early", 32'(finished), 32'd0);
        @(negedge clk);
        chk("hh_fin", 32'(finished), 32'd1);
        chk("hh_starts", 32'(mon_n), 32'd64);
        chk("hh_seq", 32'(mon_bad), 32'd0);
        rdAddr = 6'd0; #1;
        chk("hh_res0", 32'(rdData), 32'h1FFFEFF);
        rdAddr = 6'd40; #1;
        chk("hh_res40", 32'(rdData), 32'h1FFFED7);

        // Asynchronous reset mid-run
        mode = 1; dly = 0; mon_n = 0; mon_bad = 0;
        pulse_go();
        begin
            int t;
            t = 0;
            while (!(cif.count == 6'd17 && busy && !cif.start) && t < 2000) begin
                @(negedge clk);
                t++;
            end
            chk("reach_17", 32'(cif.count), 32'd17);
        end
        rst = 1'b0; #1;
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_start", 32'(cif.start), 32'd0);
        chk("ar_count", 32'(cif.count), 32'd0);
        rdAddr = 6'd16; #1;
        chk("ar_res16", 32'(rdData), 32'h1FFFEEF);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("ar_idle_start", 32'(cif.start), 32'd0);
        mon_n = 0; mon_bad = 0;
        pulse_go();
        chk("ar_restart_count", 32'(cif.count), 32'd0);
        chk("ar_restart_line", 32'(cif.line), 32'h100);
        wait_done("run4_done");
        chk("run4_seq", 32'(mon_bad), 32'd0);

        // Same-cycle write and go
        mon_n = 0; mon_bad = 0;
        @(negedge clk);
        wrEn = 1'b1; wrAddr = '0; wrData = 25'h1234567; go = 1'b1;
        @(negedge clk);
        wrEn = 1'b0; go = 1'b0;
        #2;
        chk("wg_start", 32'(cif.start), 32'd1);
        chk("wg_old_line", 32'(cif.line), 32'h100);
        tb_in[0] = 25'h1234567;
        wait_done("run5_done");
        chk("run5_seq", 32'(mon_bad), 32'd0);
        mon_n = 0; mon_bad = 0;
        pulse_go();
        chk("wg_new_line", 32'(cif.line), 32'h1234567);
        wait_done("run6_done");
        chk("run6_seq", 32'(mon_bad), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule

// File: doc/line_feeder.md
Name: line_feeder

Overview:
- Upstream sequencer for the Controller/Datapath line-processing core.
- Holds a 64-entry × 25-bit input line buffer loaded by a host write port, and issues lines one at a time to the core with a `start`/`done` handshake.
- Drives `count` and `line` into the core, and captures each 25-bit core result (`mem`) into a 64-entry result buffer readable by the host.
- Replaces the bench-side fixed-delay line stepping with a real handshake.

Parameters:
- WIDTH, 25, bits per line and per result
- DEPTH, 64, number of lines per run
- AW, 6, address/count width (log2 DEPTH)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- wrEn  in  1  host write strobe into input line buffer
- wrAddr  in  AW  input buffer write address
- wrData  in  WIDTH  input buffer write data
- go  in  1  one-cycle pulse, begins a run of DEPTH lines
- coreDone  in  1  core finished the current line (Datapath `done`)
- coreResult  in  WIDTH  core output word (Datapath `mem`), valid when `coreDone`=1
- rdAddr  in  AW  host read address into result buffer
- rdData  out  WIDTH  result buffer contents at `rdAddr`, combinational read
- line  out  WIDTH  current line presented to core, registered
- count  out  AW  index of current line, registered
- start  out  1  one-cycle pulse telling core to begin the current line
- busy  out  1  high from accepted `go` until the run completes
- finished  out  1  sticky run-complete flag, cleared by next accepted `go`

Behaviour:
- Reset (rst=0, async):
  - `line`=0, `count`=0, `start`=0, `busy`=0, `finished`=0, state IDLE.
  - Buffer contents are not reset.
  - Reset mid-run aborts to IDLE; no further `start`; both buffers retain their data.
- FSM states: IDLE, ISSUE, WAIT, FINISH. Moore outputs:
  - `start`=1 only in ISSUE.
  - `busy`=1 in ISSUE and WAIT.
- IDLE:
  - `wrEn`=1 writes `wrData` to `inbuf[wrAddr]` at the edge.
  - `go`=1 → `count`<=0, `line`<=`inbuf[0]`, `finished`<=0, next ISSUE.
  - `wrEn` and `go` in the same cycle: the write completes; `line` takes the pre-write value of `inbuf[0]`.
- ISSUE: lasts exactly 1 cycle → WAIT. `coreDone` in ISSUE is ignored.
- WAIT: stays in WAIT until `coreDone`=1. On `coreDone`:
  - `resbuf[count]`<=`coreResult`.
  - If `count`==DEPTH-1 → FINISH, and `count` holds at 63 (no wrap to 0).
  - Otherwise `count`<=`count`+1, `line`<=`inbuf[count+1]`, next ISSUE.
- FINISH: `finished`<=1, next IDLE. `finished` stays high until the next accepted `go`.
- Ignored inputs:
  - `go` while `busy`=1 is ignored.
  - `wrEn` while `busy`=1 is ignored; the input buffer is frozen during a run.
- Latency:
  - `go` at edge k → `start`=1 during cycle k+1.
  - `coreDone` at edge k → next `start` during cycle k+1.
  - Last `coreDone` → `busy`=0 one cycle later, `finished`=1 two cycles later.
- `rdData` is combinational from `resbuf[rdAddr]`. It is readable at any time; a location written at edge k reads the new value after k.
- Hold stability: `line` and `count` are stable from ISSUE through the end of WAIT, so the core may sample them at any point in that interval.

Decomposition:
- Shared package `line_pkg`:
  - WIDTH, DEPTH, AW constants.
  - State encoding localparams: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, FINISH=2'd3.
- One sub-module `line_ram`: DEPTH × WIDTH, synchronous write, asynchronous read. Instantiated twice (`inbuf`, `resbuf`).
- FSM and `count`/`line` registers live in `line_feeder`.

Test Plan:
- Reset with all inputs idle → `line`=0, `count`=0, `start`=0, `busy`=0, `finished`=0. Release rst and hold 5 cycles → outputs unchanged.
- Load `inbuf[i]`=i+25'h100 for i=0..63, pulse `go`; core model asserts `coreDone` 3 cycles after each `start` with `coreResult`=`line`^25'h1FFFFFF:
  - 64 `start` pulses observed; `count` steps 0..63.
  - `rdData` at addr 5 = 25'h105^25'h1FFFFFF.
  - `finished`=1 and `count`=63 at end.
- `go` pulse in cycle 10 of a run, plus `wrEn` to addr 0 with 25'h0AAAAAA mid-run → no restart, `inbuf[0]` unchanged. A second run shows `line`=25'h100 at `count`=0.
- `coreDone` held high continuously → one line per 2 cycles (ISSUE/WAIT alternating); the run completes 128 cycles after `go` with all 64 results captured.
- Assert rst=0 while `count`=17 in WAIT → immediately `busy`=0, `start`=0, `count`=0. `rdData` at addr 16 still holds the captured result. A new `go` restarts from `count`=0.
- Same-cycle `wrEn`(addr 0, 25'h1234567) and `go` → first `line`=old `inbuf[0]`. A second run presents 25'h1234567.
